hazard_forward_ctrl: RTL and testbench

- Parametrised successor of the single-issue MEM/WB forward unit.
- Generalised to NUM_SRC source operands and FWD_STAGES bypass stages, with priority given to the nearest stage.
- Adds a load-use stall and a long-latency-op scoreboard: a one-outstanding FSM with a countdown that produces stalls for RAW/WAW hazards against the pending destination.
- Sits between ID/EX control and the EX operand muxes; drives pipeline stall/bubble.

---
 rtl/hazard_forward_ctrl_pkg.sv | 40 ++++
 rtl/hazard_forward_ctrl_if.sv | 51 +++++
 rtl/hazard_forward_ctrl_lop_scoreboard.sv | 92 +++++++++
 rtl/hazard_forward_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_forward_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard / forwarding controller (package hazard_pkg).
// Holds register-address constants, the long-op FSM state type and the
// per-operand bypass selection function used by the top level.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // The selection function is written for the widest legal bypass network;
  // callers pad unused stages with write-enable 0 and keep the low SELW bits.
  localparam int MAX_STAGES = 4;
  localparam int MAX_SELW   = 3;

  typedef enum logic {
    LOP_IDLE = 1'b0,
    LOP_BUSY = 1'b1
  } lop_state_e;

  // Returns the nearest bypass stage (1 = MEM) producing rs, or 0 for regfile.
  // x0 and unread operands never forward.
  function automatic logic [MAX_SELW-1:0] fwd_select(
    input logic [REG_AW-1:0]            rs,
    input logic                         rs_rd,
    input logic [MAX_STAGES*REG_AW-1:0] stg_rd,
    input logic [MAX_STAGES-1:0]        stg_regwr
  );
    logic [MAX_SELW-1:0] sel;
    sel = '0;
    if (rs_rd && (rs != REG_ZERO)) begin
      // Scan oldest to nearest so the nearest matching stage overwrites.
      for (int s = MAX_STAGES; s >= 1; s--) begin
        if (stg_regwr[s-1] && (stg_rd[(s-1)*REG_AW +: REG_AW] == rs)) begin
          sel = MAX_SELW'(s);
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Bundle of pipeline control signals exchanged with the hazard controller.
// The pipeline side uses modport master, the controller uses modport slave.
// Optional macro HAZ_PERF_EN adds the two performance counter outputs.
interface hazard_forward_ctrl_if
  import hazard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int SELW       = $clog2(FWD_STAGES + 1)
) ();

  logic [NUM_SRC*REG_AW-1:0]    ex_rs;
  logic [NUM_SRC-1:0]           ex_rs_rd;
  logic [FWD_STAGES*REG_AW-1:0] stg_rd;
  logic [FWD_STAGES-1:0]        stg_regwr;
  logic [NUM_SRC*REG_AW-1:0]    id_rs;
  logic [NUM_SRC-1:0]           id_rs_rd;
  logic [REG_AW-1:0]            id_rd;
  logic                         id_regwr;
  logic                         id_lop;
  logic                         ex_is_load;
  logic [REG_AW-1:0]            ex_rd;
  logic                         flush;
  logic [NUM_SRC*SELW-1:0]      fwd_sel;
  logic                         stall;
  logic                         lop_busy;
  logic                         lop_done;
`ifdef HAZ_PERF_EN
  logic [31:0]                  perf_stall_cyc;
  logic [31:0]                  perf_fwd_cnt;
`endif

  modport master (
    output ex_rs, ex_rs_rd, stg_rd, stg_regwr, id_rs, id_rs_rd, id_rd,
           id_regwr, id_lop, ex_is_load, ex_rd, flush,
    input  fwd_sel, stall, lop_busy, lop_done
`ifdef HAZ_PERF_EN
    , input perf_stall_cyc, perf_fwd_cnt
`endif
  );

  modport slave (
    input  ex_rs, ex_rs_rd, stg_rd, stg_regwr, id_rs, id_rs_rd, id_rd,
           id_regwr, id_lop, ex_is_load, ex_rd, flush,
    output fwd_sel, stall, lop_busy, lop_done
`ifdef HAZ_PERF_EN
    , output perf_stall_cyc, perf_fwd_cnt
`endif
  );

endinterface

// File: rtl/hazard_forward_ctrl_lop_scoreboard.sv
// Single-outstanding long-latency-op tracker. Holds the pending destination
// and a countdown; raises lop_hz for RAW, WAW and structural hazards against
// the op in flight. An op that has issued is never cancelled by a flush.
module lop_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int LOP_LAT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_rd,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwr,
  input  logic                      id_lop,
  input  logic                      luse,
  input  logic                      flush,
  output logic                      lop_hz,
  output logic                      lop_busy,
  output logic                      lop_done
);

  lop_state_e        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;

  logic [NUM_SRC-1:0] raw_hit;
  logic               busy;
  logic               pend_live;
  logic               waw_hit;
  logic               accept;

  assign busy      = (state_q == LOP_BUSY);
  assign pend_live = (pend_rd_q != REG_ZERO);
  assign waw_hit   = id_regwr && (id_rd == pend_rd_q);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_raw
    assign raw_hit[gi] = id_rs_rd[gi] && (id_rs[gi*REG_AW +: REG_AW] == pend_rd_q);
  end

  // In IDLE lop_hz is low, so the only stall source is load-use.
  assign accept = id_lop && !luse && !flush;

  // Hazard, busy and completion flags derived from the registered state.
  always_comb begin
    lop_hz   = 1'b0;
    lop_busy = busy;
    lop_done = busy && (cnt_q == 6'd0);
    if (busy) begin
      lop_hz = id_lop || (pend_live && ((|raw_hit) || waw_hit));
    end
  end

  // Next-state logic: issue from IDLE, count down in BUSY, release at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    unique case (state_q)
      LOP_IDLE: begin
        if (accept) begin
          state_d   = LOP_BUSY;
          cnt_d     = 6'(LOP_LAT - 1);
          pend_rd_d = id_rd;
        end
      end
      LOP_BUSY: begin
        if (cnt_q == 6'd0) begin
          state_d   = LOP_IDLE;
          pend_rd_d = REG_ZERO;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
    endcase
  end

  // State registers; reset aborts any op in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOP_IDLE;
      cnt_q     <= 6'd0;
      pend_rd_q <= REG_ZERO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding and pipeline stall control for the EX stage.
// Forward selects are combinational with nearest-stage priority; stalls come
// from load-use and from the long-op scoreboard, both masked by flush.
// Optional macro HAZ_PERF_EN adds saturating stall-cycle and forward counters.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOP_LAT    = 8,
  parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_ctrl_if.slave bus
);

  logic [MAX_STAGES*REG_AW-1:0] stg_rd_pad;
  logic [MAX_STAGES-1:0]        stg_regwr_pad;
  logic [MAX_SELW-1:0]          sel_full [NUM_SRC];
  logic [NUM_SRC-1:0]           sel_hi_unused;
  logic [NUM_SRC*SELW-1:0]      fwd_sel_w;
  logic [NUM_SRC-1:0]           id_hits_ex;
  logic                         luse;
  logic                         lop_hz;
  logic                         stall_w;

  // Widen the bypass network to the selection function's fixed width.
  always_comb begin
    stg_rd_pad    = '0;
    stg_regwr_pad = '0;
    stg_rd_pad[FWD_STAGES*REG_AW-1:0] = bus.stg_rd;
    stg_regwr_pad[FWD_STAGES-1:0]     = bus.stg_regwr;
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign sel_full[gi] = fwd_select(bus.ex_rs[gi*REG_AW +: REG_AW], bus.ex_rs_rd[gi],
                                     stg_rd_pad, stg_regwr_pad);
    // High bits are always zero for legal FWD_STAGES.
    assign sel_hi_unused[gi] = |(sel_full[gi] >> SELW);
    assign fwd_sel_w[gi*SELW +: SELW] = sel_full[gi][SELW-1:0];
    assign id_hits_ex[gi] = bus.id_rs_rd[gi] &&
                            (bus.id_rs[gi*REG_AW +: REG_AW] == bus.ex_rd);
  end

  assign luse = bus.ex_is_load && (bus.ex_rd != REG_ZERO) && (|id_hits_ex) && !bus.flush;

  lop_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .LOP_LAT (LOP_LAT)
  ) u_lop (
    .clk      (clk),
    .rst      (rst),
    .id_rs    (bus.id_rs),
    .id_rs_rd (bus.id_rs_rd),
    .id_rd    (bus.id_rd),
    .id_regwr (bus.id_regwr),
    .id_lop   (bus.id_lop),
    .luse     (luse),
    .flush    (bus.flush),
    .lop_hz   (lop_hz),
    .lop_busy (bus.lop_busy),
    .lop_done (bus.lop_done)
  );

  assign stall_w     = (luse || lop_hz) && !bus.flush;
  assign bus.stall   = stall_w;
  assign bus.fwd_sel = fwd_sel_w;

`ifdef HAZ_PERF_EN
  logic [31:0]                    perf_stall_cyc_q, perf_stall_cyc_d;
  logic [31:0]                    perf_fwd_cnt_q, perf_fwd_cnt_d;
  logic [$clog2(NUM_SRC+1)-1:0]   fwd_active;
  logic [32:0]                    fwd_sum;

  // Saturating counters: stall cycles and number of forwarded operands.
  always_comb begin
    fwd_active = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (fwd_sel_w[k*SELW +: SELW] != '0) begin
        fwd_active = fwd_active + 1'b1;
      end
    end
    fwd_sum          = {1'b0, perf_fwd_cnt_q} + 33'(fwd_active);
    perf_fwd_cnt_d   = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    perf_stall_cyc_d = perf_stall_cyc_q;
    if (stall_w && (perf_stall_cyc_q != 32'hFFFF_FFFF)) begin
      perf_stall_cyc_d = perf_stall_cyc_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc_q <= '0;
      perf_fwd_cnt_q   <= '0;
    end else begin
      perf_stall_cyc_q <= perf_stall_cyc_d;
      perf_fwd_cnt_q   <= perf_fwd_cnt_d;
    end
  end

  assign bus.perf_stall_cyc = perf_stall_cyc_q;
  assign bus.perf_fwd_cnt   = perf_fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: a driver issues directed and
// random stimulus and queues the reference model's expected outputs; a
// negedge monitor pops and compares. Honours HAZ_PERF_EN when defined.
module tb_hazard_forward_ctrl;
  import hazard_pkg::*;

  localparam int NS   = 2;
  localparam int FS   = 2;
  localparam int LAT  = 8;
  localparam int SELW = $clog2(FS + 1);
  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.NUM_SRC(NS), .FWD_STAGES(FS)) bus ();

  hazard_forward_ctrl #(
    .NUM_SRC(NS), .FWD_STAGES(FS), .LOP_LAT(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [NS*SELW-1:0] fwd_sel;
    logic               stall;
    logic               busy;
    logic               done;
    logic [31:0]        pst;
    logic [31:0]        pfc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Stimulus, kept as plain integers.
  int s_ex_rs[NS];
  bit s_ex_rs_rd[NS];
  int s_stg_rd[FS];
  bit s_stg_regwr[FS];
  int s_id_rs[NS];
  bit s_id_rs_rd[NS];
  int s_id_rd, s_ex_rd;
  bit s_id_regwr, s_id_lop, s_ex_is_load, s_flush;

  // Reference model: remaining busy cycles of the op in flight and its rd.
  int     m_rem = 0, m_pend = 0, m_rem_n = 0, m_pend_n = 0;
  longint m_pst = 0, m_pfc = 0, m_pst_n = 0, m_pfc_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < NS; k++) begin
      s_ex_rs[k] = 0; s_ex_rs_rd[k] = 0; s_id_rs[k] = 0; s_id_rs_rd[k] = 0;
    end
    for (int s = 0; s < FS; s++) begin
      s_stg_rd[s] = 0; s_stg_regwr[s] = 0;
    end
    s_id_rd = 0; s_ex_rd = 0; s_id_regwr = 0; s_id_lop = 0; s_ex_is_load = 0; s_flush = 0;
  endtask

  task automatic apply();
    for (int k = 0; k < NS; k++) begin
      bus.ex_rs[k*5 +: 5] = 5'(s_ex_rs[k]);
      bus.ex_rs_rd[k]     = s_ex_rs_rd[k];
      bus.id_rs[k*5 +: 5] = 5'(s_id_rs[k]);
      bus.id_rs_rd[k]     = s_id_rs_rd[k];
    end
    for (int s = 0; s < FS; s++) begin
      bus.stg_rd[s*5 +: 5] = 5'(s_stg_rd[s]);
      bus.stg_regwr[s]     = s_stg_regwr[s];
    end
    bus.id_rd = 5'(s_id_rd); bus.ex_rd = 5'(s_ex_rd);
    bus.id_regwr = s_id_regwr; bus.id_lop = s_id_lop;
    bus.ex_is_load = s_ex_is_load; bus.flush = s_flush;
  endtask

  function automatic int ref_fwd(int k);
    if (!s_ex_rs_rd[k] || s_ex_rs[k] == 0) return 0;
    for (int s = 1; s <= FS; s++)
      if (s_stg_regwr[s-1] && s_stg_rd[s-1] == s_ex_rs[k]) return s;
    return 0;
  endfunction

  function automatic bit id_reads(int r);
    for (int k = 0; k < NS; k++)
      if (s_id_rs_rd[k] && s_id_rs[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval(output exp_t e);
    bit busy, luse, hz, st;
    int nfwd, f;
    nfwd = 0;
    busy = (m_rem > 0);
    luse = s_ex_is_load && s_ex_rd != 0 && id_reads(s_ex_rd);
    hz   = busy && (s_id_lop || (m_pend != 0 &&
           (id_reads(m_pend) || (s_id_regwr && s_id_rd == m_pend))));
    st   = (luse || hz) && !s_flush;
    e.fwd_sel = '0;
    for (int k = 0; k < NS; k++) begin
      f = ref_fwd(k);
      e.fwd_sel[k*SELW +: SELW] = SELW'(f);
      if (f != 0) nfwd++;
    end
    e.stall = st; e.busy = busy; e.done = (m_rem == 1);
    e.pst = 32'(m_pst); e.pfc = 32'(m_pfc);
    if (busy) begin
      m_rem_n  = m_rem - 1;
      m_pend_n = (m_rem == 1) ? 0 : m_pend;
    end else if (s_id_lop && !st && !s_flush) begin
      m_rem_n = LAT; m_pend_n = s_id_rd;
    end else begin
      m_rem_n = 0; m_pend_n = 0;
    end
    m_pst_n = (st && m_pst < MAXC) ? m_pst + 1 : m_pst;
    m_pfc_n = (m_pfc + nfwd > MAXC) ? MAXC : m_pfc + nfwd;
  endtask

  // One clock of stimulus: advance model at the edge, drive, queue expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    m_rem = m_rem_n; m_pend = m_pend_n; m_pst = m_pst_n; m_pfc = m_pfc_n;
    #1;
    apply();
    #1;
    model_eval(e);
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] act_sel(int k);
    return 32'(bus.fwd_sel[k*SELW +: SELW]);
  endfunction

  // Monitor: compare every queued expectation on the falling edge.
  initial begin : monitor
    exp_t e;
    int txn;
    txn = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_sel",  32'(bus.fwd_sel),  32'(e.fwd_sel));
        check("stall",    32'(bus.stall),    32'(e.stall));
        check("lop_busy", 32'(bus.lop_busy), 32'(e.busy));
        check("lop_done", 32'(bus.lop_done), 32'(e.done));
`ifdef HAZ_PERF_EN
        check("perf_stall_cyc", bus.perf_stall_cyc, e.pst);
        check("perf_fwd_cnt",   bus.perf_fwd_cnt,   e.pfc);
`endif
        $display("txn %0d sel=%0h stall=%0b busy=%0b done=%0b", txn, bus.fwd_sel,
                 bus.stall, bus.lop_busy, bus.lop_done);
        txn++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    clear_stim();
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(bus.lop_busy), 32'd0);
    check("rst_done",  32'(bus.lop_done), 32'd0);
    check("rst_stall", 32'(bus.stall),    32'd0);
`ifdef HAZ_PERF_EN
    check("rst_perf_stall", bus.perf_stall_cyc, 32'd0);
    check("rst_perf_fwd",   bus.perf_fwd_cnt,   32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Nearest-stage priority.
    clear_stim();
    s_ex_rs[0] = 5; s_ex_rs_rd[0] = 1;
    s_stg_rd[0] = 5; s_stg_rd[1] = 5; s_stg_regwr[0] = 1; s_stg_regwr[1] = 1;
    step(); check("prio_nearest", act_sel(0), 32'd1);
    s_stg_regwr[0] = 0;
    step(); check("prio_older", act_sel(0), 32'd2);
    s_ex_rs[0] = 0;
    step(); check("prio_x0", act_sel(0), 32'd0);

    // Read-enable mask.
    clear_stim();
    s_ex_rs[1] = 7; s_ex_rs_rd[1] = 0; s_stg_rd[0] = 7; s_stg_regwr[0] = 1;
    step(); check("rd_mask", act_sel(1), 32'd0);

    // Load-use: one cycle, then masked by flush.
    clear_stim();
    s_ex_is_load = 1; s_ex_rd = 9; s_id_rs[1] = 9; s_id_rs_rd[1] = 1;
    step(); check("luse_stall", 32'(bus.stall), 32'd1);
    s_ex_is_load = 0;
    step(); check("luse_release", 32'(bus.stall), 32'd0);
    s_ex_is_load = 1; s_flush = 1;
    step(); check("luse_flush", 32'(bus.stall), 32'd0);

    // Long op to r12 with r12 read while in flight.
    clear_stim();
    s_id_lop = 1; s_id_rd = 12; s_id_regwr = 1;
    step(); check("lop_issue_stall", 32'(bus.stall), 32'd0);
    clear_stim();
    s_id_rs[0] = 12; s_id_rs_rd[0] = 1;
    for (int i = 0; i < LAT; i++) begin
      step();
      check("lop_busy_window", 32'(bus.lop_busy), 32'd1);
      check("lop_raw_stall",   32'(bus.stall),    32'd1);
      check("lop_done_pulse",  32'(bus.lop_done), (i == LAT - 1) ? 32'd1 : 32'd0);
    end
    step();
    check("lop_after_busy",  32'(bus.lop_busy), 32'd0);
    check("lop_after_stall", 32'(bus.stall),    32'd0);

    // Long op with an unrelated read of r13.
    clear_stim();
    s_id_lop = 1; s_id_rd = 12;
    step();
    clear_stim();
    s_id_rs[0] = 13; s_id_rs_rd[0] = 1;
    for (int i = 0; i < LAT; i++) begin
      step(); check("lop_no_raw", 32'(bus.stall), 32'd0);
    end

    // WAW then structural; second op issues the cycle after done.
    clear_stim();
    s_id_lop = 1; s_id_rd = 12;
    step();
    clear_stim();
    s_id_regwr = 1; s_id_rd = 12;
    step(); check("waw_stall", 32'(bus.stall), 32'd1);
    clear_stim();
    s_id_lop = 1; s_id_rd = 5;
    for (int i = 1; i < LAT; i++) begin
      step(); check("struct_stall", 32'(bus.stall), 32'd1);
    end
    check("struct_done", 32'(bus.lop_done), 32'd1);
    step(); check("second_issue", 32'(bus.stall), 32'd0);
    clear_stim();
    step(); check("second_busy", 32'(bus.lop_busy), 32'd1);
    repeat (LAT) step();

    // Reset mid-op at cnt=3.
    clear_stim();
    s_id_lop = 1; s_id_rd = 12;
    step();
    clear_stim();
    s_id_rs[0] = 12; s_id_rs_rd[0] = 1;
    repeat (5) step();
    check("pre_rst_stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  32'(bus.lop_busy), 32'd0);
    check("mid_rst_stall", 32'(bus.stall),    32'd0);
    check("mid_rst_done",  32'(bus.lop_done), 32'd0);
`ifdef HAZ_PERF_EN
    check("mid_rst_perf_stall", bus.perf_stall_cyc, 32'd0);
    check("mid_rst_perf_fwd",   bus.perf_fwd_cnt,   32'd0);
`endif
    m_rem = 0; m_pend = 0; m_rem_n = 0; m_pend_n = 0;
    m_pst = 0; m_pfc = 0; m_pst_n = 0; m_pfc_n = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_done", 32'(bus.lop_done), 32'd0);
    end
    #1;
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NS; k++) begin
        s_ex_rs[k] = $urandom_range(0, 7); s_ex_rs_rd[k] = 1'($urandom_range(0, 3) != 0);
        s_id_rs[k] = $urandom_range(0, 7); s_id_rs_rd[k] = 1'($urandom_range(0, 3) != 0);
      end
      for (int s = 0; s < FS; s++) begin
        s_stg_rd[s] = $urandom_range(0, 7); s_stg_regwr[s] = 1'($urandom_range(0, 1));
      end
      s_id_rd      = $urandom_range(0, 7);
      s_ex_rd      = $urandom_range(0, 7);
      s_id_regwr   = 1'($urandom_range(0, 1));
      s_id_lop     = 1'($urandom_range(0, 7) == 0);
      s_ex_is_load = 1'($urandom_range(0, 2) == 0);
      s_flush      = 1'($urandom_range(0, 9) == 0);
      step();
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
